rv32i_pipe_ctrl: RTL

//  Pipelined RV32I control unit: decodes the ID-stage instruction into a control bundle and carries it

---
 rtl/rv32i_ctrl_pkg.sv | 84 ++++++++
 rtl/rv32i_decode.sv | 114 +++++++++++
 rtl/rv32i_pipe_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings and the control bundle carried from ID down to WB.
package rv32i_ctrl_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'h0,
    ALU_SUB    = 4'h1,
    ALU_AND    = 4'h2,
    ALU_OR     = 4'h3,
    ALU_XOR    = 4'h4,
    ALU_SLL    = 4'h5,
    ALU_SRL    = 4'h6,
    ALU_SRA    = 4'h7,
    ALU_SLT    = 4'h8,
    ALU_SLTU   = 4'h9,
    ALU_PASS_B = 4'hA
  } alu_op_e;

  typedef enum logic [3:0] {
    IMM_I = 4'd0,
    IMM_S = 4'd1,
    IMM_B = 4'd2,
    IMM_U = 4'd3,
    IMM_J = 4'd4
  } imm_src_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } ld_size_e;

  typedef struct packed {
    alu_op_e    alu_ctrl;
    logic       alu_src;
    logic       alu_src_a;
    imm_src_e   imm_src;
    logic       pcs_dire;
    logic       pc_4;
    logic       mem_write;
    ld_size_e   load_size;
    logic       load_uns;
    logic       mem_to_reg;
    logic       reg_write;
    logic [4:0] rd;
    logic       is_load;
    logic       is_branch;
    logic       is_jal;
    logic       is_jalr;
    logic       illegal;
  } ctrl_bundle_t;

  // ALU op for OP / OP-IMM; alt selects SUB/SRA (funct7 bit 5)
  function automatic alu_op_e alu_from_funct(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      3'd7:    op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_decode.sv
// Combinational ID-stage decoder: instruction word -> control bundle plus
// register-use flags for hazard detection. Undecodable words yield an empty
// bundle tagged illegal, which can never write state or redirect.
module rv32i_decode
  import rv32i_ctrl_pkg::*;
(
  input  logic [31:0]  instr,
  output ctrl_bundle_t ctrl,
  output logic         use_rs1,
  output logic         use_rs2
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_field;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rd_field = instr[11:7];

  // Opcode/funct decode into the control bundle
  always_comb begin
    ctrl_bundle_t b;
    logic legal;
    logic writes;
    logic u1;
    logic u2;
    b      = '0;
    legal  = 1'b0;
    writes = 1'b0;
    u1     = 1'b0;
    u2     = 1'b0;
    case (opcode)
      OP_LUI: begin
        legal = 1'b1; writes = 1'b1;
        b.alu_ctrl = ALU_PASS_B; b.alu_src = 1'b1; b.imm_src = IMM_U;
      end
      OP_AUIPC: begin
        legal = 1'b1; writes = 1'b1;
        b.alu_ctrl = ALU_ADD; b.alu_src = 1'b1; b.alu_src_a = 1'b1; b.imm_src = IMM_U;
      end
      OP_JAL: begin
        legal = 1'b1; writes = 1'b1;
        b.alu_ctrl = ALU_ADD; b.alu_src = 1'b1; b.alu_src_a = 1'b1; b.imm_src = IMM_J;
        b.pc_4 = 1'b1; b.is_jal = 1'b1;
      end
      OP_JALR: begin
        legal = (funct3 == 3'd0); writes = 1'b1; u1 = 1'b1;
        b.alu_ctrl = ALU_ADD; b.alu_src = 1'b1; b.imm_src = IMM_I;
        b.pcs_dire = 1'b1; b.pc_4 = 1'b1; b.is_jalr = 1'b1;
      end
      OP_BRANCH: begin
        legal = (funct3[2:1] != 2'b01); u1 = 1'b1; u2 = 1'b1;
        b.alu_ctrl  = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        b.imm_src   = IMM_B;
        b.is_branch = 1'b1;
      end
      OP_LOAD: begin
        // LB LH LW LBU LHU only
        legal = (funct3[1:0] != 2'b11) && !(funct3[2] && funct3[1]);
        writes = 1'b1; u1 = 1'b1;
        b.alu_ctrl = ALU_ADD; b.alu_src = 1'b1; b.imm_src = IMM_I;
        b.mem_to_reg = 1'b1; b.is_load = 1'b1;
        b.load_size = ld_size_e'(funct3[1:0]); b.load_uns = funct3[2];
      end
      OP_STORE: begin
        legal = !funct3[2] && (funct3[1:0] != 2'b11); u1 = 1'b1; u2 = 1'b1;
        b.alu_ctrl = ALU_ADD; b.alu_src = 1'b1; b.imm_src = IMM_S;
        b.mem_write = 1'b1; b.load_size = ld_size_e'(funct3[1:0]);
      end
      OP_IMM: begin
        if (funct3 == 3'd1) begin
          legal = (funct7 == F7_BASE);
        end else if (funct3 == 3'd5) begin
          legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        end else begin
          legal = 1'b1;
        end
        writes = 1'b1; u1 = 1'b1;
        b.alu_ctrl = alu_from_funct(funct3, (funct3 == 3'd5) && funct7[5]);
        b.alu_src  = 1'b1; b.imm_src = IMM_I;
      end
      OP_REG: begin
        legal = (funct7 == F7_BASE) ||
                ((funct7 == F7_ALT) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
        writes = 1'b1; u1 = 1'b1; u2 = 1'b1;
        b.alu_ctrl = alu_from_funct(funct3, funct7[5]);
      end
      OP_FENCE, OP_SYSTEM: begin
        // No architectural effect on this control path
        legal = 1'b1;
      end
      default: begin
        legal = 1'b0;
      end
    endcase

    if (legal) begin
      b.reg_write = writes && (rd_field != 5'd0);
      b.rd        = b.reg_write ? rd_field : 5'd0;
      ctrl        = b;
      use_rs1     = u1;
      use_rs2     = u2;
    end else begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
      use_rs1      = 1'b0;
      use_rs2      = 1'b0;
    end
  end

endmodule

// File: rtl/rv32i_pipe_ctrl.sv
// Pipelined RV32I control: decodes in ID, then carries the bundle through
// valid-tagged EX/MEM/WB registers. Handles load-use stall and taken-redirect
// flush on the ID->EX boundary; MEM and WB advance every cycle.
module rv32i_pipe_ctrl
  import rv32i_ctrl_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int HAZARD_EN   = 1,
  parameter int FLUSH_SLOTS = 1
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       Instr,
  output logic              id_ready,
  input  logic              Condex,
  output logic [3:0]        ALUControl,
  output logic              ALUSrc,
  output logic              ALUSrc_A,
  output logic [3:0]        ImmSrc,
  output logic              PCSrc,
  output logic              PCS_dire,
  output logic              PC_4,
  output logic              flush_if,
  output logic              MemWrite,
  output logic [1:0]        Load_size,
  output logic              Load_uns,
  output logic              MemtoReg,
  output logic              RegWrite,
  output logic [REG_AW-1:0] wb_rd,
  output logic              illegal
);

  ctrl_bundle_t id_ctrl;
  ctrl_bundle_t ex_ctrl;
  ctrl_bundle_t mem_ctrl;
  ctrl_bundle_t wb_ctrl;
  logic         id_use_rs1;
  logic         id_use_rs2;
  logic         ex_valid;
  logic         mem_valid;
  logic         wb_valid;
  logic         redirect;
  logic         load_use;
  logic         stall;
  logic         wb_unused;

  rv32i_decode u_decode (
    .instr   (Instr),
    .ctrl    (id_ctrl),
    .use_rs1 (id_use_rs1),
    .use_rs2 (id_use_rs2)
  );

  // Taken redirect from the EX slot; Condex only matters for branches
  always_comb begin
    redirect = ex_valid & (ex_ctrl.is_jal | ex_ctrl.is_jalr | (ex_ctrl.is_branch & Condex));
  end

  // Load-use: the ID instruction reads the register a load in EX will write
  always_comb begin
    if (HAZARD_EN != 0) begin
      load_use = id_valid && ex_valid && ex_ctrl.is_load && (ex_ctrl.rd != 5'd0) &&
                 ((id_use_rs1 && (Instr[19:15] == ex_ctrl.rd)) ||
                  (id_use_rs2 && (Instr[24:20] == ex_ctrl.rd)));
    end else begin
      load_use = 1'b0;
    end
    // A redirect discards the ID instruction anyway, so it overrides the stall
    stall = load_use & ~redirect;
  end

  // ID->EX advances unless stalled or flushed; MEM and WB always shift
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_ctrl   <= '0;
      mem_valid <= 1'b0;
      mem_ctrl  <= '0;
      wb_valid  <= 1'b0;
      wb_ctrl   <= '0;
    end else begin
      if (redirect || stall || !id_valid) begin
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
      end else begin
        ex_valid <= 1'b1;
        ex_ctrl  <= id_ctrl;
      end
      mem_valid <= ex_valid;
      mem_ctrl  <= ex_ctrl;
      wb_valid  <= mem_valid;
      wb_ctrl   <= mem_ctrl;
    end
  end

  // Stage-gated control outputs; an empty stage drives all zeros
  always_comb begin
    id_ready = ~stall;
    if (ex_valid) begin
      ALUControl = ex_ctrl.alu_ctrl;
      ALUSrc     = ex_ctrl.alu_src;
      ALUSrc_A   = ex_ctrl.alu_src_a;
      ImmSrc     = ex_ctrl.imm_src;
      PCS_dire   = ex_ctrl.pcs_dire;
      illegal    = ex_ctrl.illegal;
    end else begin
      ALUControl = 4'd0;
      ALUSrc     = 1'b0;
      ALUSrc_A   = 1'b0;
      ImmSrc     = 4'd0;
      PCS_dire   = 1'b0;
      illegal    = 1'b0;
    end
    PCSrc    = redirect;
    flush_if = (FLUSH_SLOTS == 2) ? redirect : 1'b0;
    if (mem_valid) begin
      MemWrite  = mem_ctrl.mem_write;
      Load_size = mem_ctrl.load_size;
      Load_uns  = mem_ctrl.load_uns;
    end else begin
      MemWrite  = 1'b0;
      Load_size = 2'd0;
      Load_uns  = 1'b0;
    end
    if (wb_valid) begin
      PC_4     = wb_ctrl.pc_4;
      MemtoReg = wb_ctrl.mem_to_reg;
      RegWrite = wb_ctrl.reg_write;
      wb_rd    = wb_ctrl.rd[REG_AW-1:0];
    end else begin
      PC_4     = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      wb_rd    = '0;
    end
  end

  // WB only consumes part of the bundle
  assign wb_unused = ^wb_ctrl;

endmodule
